// File: rtl/lcd_cmd_queue.sv
// Byte queue feeding an LCD controller through a LOAD/BUSY handshake.
// Optional LOAD acknowledgement watchdog: define LCD_QUEUE_ACK_TIMEOUT_EN.
module lcd_cmd_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic                     CLK_100MHz,
    input  logic                     RESET,
    input  logic                     WR_EN,
    input  logic [7:0]               WR_DATA,
    input  logic                     WR_IS_CMD,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    input  logic                     CLR_OVERFLOW,
    output logic                     LCD_LOAD,
    output logic [7:0]               LCD_DATA,
    output logic                     LCD_IS_CMD,
    input  logic                     LCD_BUSY,
    input  logic                     LCD_READY,
    output logic                     TIMEOUT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || ACK_TIMEOUT == 0) begin : g_bad_params
        $error("lcd_cmd_queue: DEPTH must be a power of two in 2..256 and ACK_TIMEOUT nonzero");
    end

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

    state_t          state;
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic            push;
    logic            pop;
    logic            ack_hit;

    assign push = WR_EN && !FULL && !RESET;
    assign pop  = (state == LOAD) && (LCD_BUSY || ack_hit);

    always_comb begin
        count_nxt = COUNT;
        case ({push, pop})
            2'b10:   count_nxt = COUNT + CW'(1);
            2'b01:   count_nxt = COUNT - CW'(1);
            default: count_nxt = COUNT;
        endcase
    end

    // Storage array carries no reset; only pointers and COUNT define validity.
    always_ff @(posedge CLK_100MHz) begin
        if (push) begin
            mem[wr_ptr] <= {WR_IS_CMD, WR_DATA};
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            EMPTY    <= 1'b1;
            FULL     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            COUNT <= count_nxt;
            EMPTY <= (count_nxt == CW'(0));
            FULL  <= (count_nxt == CW'(DEPTH));
            // A dropped push takes priority over a simultaneous clear.
            if (WR_EN && FULL) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVERFLOW) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

    // Sender: head byte is latched on LOAD entry and held until the next LOAD.
    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            state      <= IDLE;
            LCD_LOAD   <= 1'b0;
            LCD_DATA   <= '0;
            LCD_IS_CMD <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!EMPTY && LCD_READY && !LCD_BUSY) begin
                        state                  <= LOAD;
                        LCD_LOAD               <= 1'b1;
                        {LCD_IS_CMD, LCD_DATA} <= mem[rd_ptr];
                    end
                end
                LOAD: begin
                    if (LCD_BUSY) begin
                        state    <= WAIT_DONE;
                        LCD_LOAD <= 1'b0;
                    end else if (ack_hit) begin
                        state    <= IDLE;
                        LCD_LOAD <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (!LCD_BUSY) state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    LCD_LOAD <= 1'b0;
                end
            endcase
        end
    end

`ifdef LCD_QUEUE_ACK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] ack_cnt;

    assign ack_hit = (state == LOAD) && !LCD_BUSY && (ack_cnt == TW'(ACK_TIMEOUT - 1));

    // Counts cycles spent in LOAD without acknowledgement.
    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            ack_cnt <= '0;
            TIMEOUT <= 1'b0;
        end else begin
            TIMEOUT <= ack_hit;
            if (state != LOAD || LCD_BUSY || ack_hit) begin
                ack_cnt <= '0;
            end else begin
                ack_cnt <= ack_cnt + TW'(1);
            end
        end
    end
`else
    assign ack_hit = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Directed self-checking bench for lcd_cmd_queue (DEPTH 16, ACK_TIMEOUT 1024).
module tb_lcd_cmd_queue;

    logic       CLK_100MHz = 1'b0;
    logic       RESET = 1'b1;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_DATA = '0;
    logic       WR_IS_CMD = 1'b0;
    logic       FULL;
    logic       EMPTY;
    logic [4:0] COUNT;
    logic       OVERFLOW;
    logic       CLR_OVERFLOW = 1'b0;
    logic       LCD_LOAD;
    logic [7:0] LCD_DATA;
    logic       LCD_IS_CMD;
    logic       LCD_BUSY = 1'b0;
    logic       LCD_READY = 1'b0;
    logic       TIMEOUT;

    int         n_checks = 0;
    int         n_pass = 0;
    bit         auto_ack = 1'b0;
    logic [8:0] cap[$];
    logic [8:0] exp_q[$];

    always #5 CLK_100MHz = ~CLK_100MHz;

    lcd_cmd_queue #(.DEPTH(16), .ACK_TIMEOUT(1024)) dut (
        .CLK_100MHz   (CLK_100MHz),
        .RESET        (RESET),
        .WR_EN        (WR_EN),
        .WR_DATA      (WR_DATA),
        .WR_IS_CMD    (WR_IS_CMD),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .CLR_OVERFLOW (CLR_OVERFLOW),
        .LCD_LOAD     (LCD_LOAD),
        .LCD_DATA     (LCD_DATA),
        .LCD_IS_CMD   (LCD_IS_CMD),
        .LCD_BUSY     (LCD_BUSY),
        .LCD_READY    (LCD_READY),
        .TIMEOUT      (TIMEOUT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock; optionally plays the LCD side: acknowledge LOAD, then release BUSY.
    task automatic tick();
        @(posedge CLK_100MHz);
        #1;
        if (auto_ack) begin
            if (LCD_BUSY) begin
                LCD_BUSY = 1'b0;
            end else if (LCD_LOAD) begin
                cap.push_back({LCD_IS_CMD, LCD_DATA});
                LCD_BUSY = 1'b1;
            end
        end
    endtask

    task automatic push(input logic [7:0] d, input logic c);
        WR_EN = 1'b1;
        WR_DATA = d;
        WR_IS_CMD = c;
        tick();
        WR_EN = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(EMPTY && !LCD_LOAD && !LCD_BUSY) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(n < 500), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int k;
        int pulses;

        // Reset state
        repeat (3) tick();
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_ovf", 32'(OVERFLOW), 32'd0);
        check("rst_load", 32'(LCD_LOAD), 32'd0);
        check("rst_data", 32'({LCD_IS_CMD, LCD_DATA}), 32'd0);
        check("rst_tmo", 32'(TIMEOUT), 32'd0);
        RESET = 1'b0;
        tick();

        // Single command byte: LOAD one edge after the push edge
        LCD_READY = 1'b1;
        push(8'h2A, 1'b1);
        check("s1_count", 32'(COUNT), 32'd1);
        check("s1_load_early", 32'(LCD_LOAD), 32'd0);
        tick();
        check("s1_load", 32'(LCD_LOAD), 32'd1);
        check("s1_data", 32'(LCD_DATA), 32'h2A);
        check("s1_cmd", 32'(LCD_IS_CMD), 32'd1);
        tick();
        check("s1_load_hold", 32'(LCD_LOAD), 32'd1);
        LCD_BUSY = 1'b1;
        tick();
        check("s1_load_fall", 32'(LCD_LOAD), 32'd0);
        check("s1_count0", 32'(COUNT), 32'd0);
        check("s1_empty", 32'(EMPTY), 32'd1);
        check("s1_data_hold", 32'(LCD_DATA), 32'h2A);
        LCD_BUSY = 1'b0;
        tick();
        tick();

        // Fill to full, overflow beats a same-edge clear, then drain in order
        LCD_READY = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i), i[0]);
        check("f_full", 32'(FULL), 32'd1);
        check("f_count", 32'(COUNT), 32'd16);
        check("f_ovf0", 32'(OVERFLOW), 32'd0);
        CLR_OVERFLOW = 1'b1;
        push(8'h10, 1'b0);
        CLR_OVERFLOW = 1'b0;
        check("f_ovf1", 32'(OVERFLOW), 32'd1);
        check("f_count_kept", 32'(COUNT), 32'd16);
        cap.delete();
        auto_ack = 1'b1;
        LCD_READY = 1'b1;
        drain("f");
        check("f_ncap", 32'(cap.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("f_entry", 32'(cap[i]), 32'({i[0], i[7:0]}));
        check("f_ovf_sticky", 32'(OVERFLOW), 32'd1);
        CLR_OVERFLOW = 1'b1;
        tick();
        CLR_OVERFLOW = 1'b0;
        check("f_ovf_clr", 32'(OVERFLOW), 32'd0);

        // 20 bytes with continuous handshaking: pointers wrap
        cap.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back({1'(i % 3 == 0), 8'(8'h40 + 8'(i))});
            push(8'(8'h40 + 8'(i)), 1'(i % 3 == 0));
        end
        drain("w");
        check("w_ncap", 32'(cap.size()), 32'd20);
        for (int i = 0; i < 20; i++) check("w_entry", 32'(cap[i]), 32'(exp_q[i]));

        // Push and pop on the same edge with COUNT 3
        auto_ack = 1'b0;
        LCD_READY = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        check("pp_count3", 32'(COUNT), 32'd3);
        LCD_READY = 1'b1;
        tick();
        check("pp_load", 32'({LCD_LOAD, LCD_IS_CMD, LCD_DATA}), 32'h311);
        LCD_BUSY = 1'b1;
        push(8'h44, 1'b0);
        check("pp_count_same", 32'(COUNT), 32'd3);
        check("pp_load_fall", 32'(LCD_LOAD), 32'd0);
        LCD_BUSY = 1'b0;
        cap.delete();
        auto_ack = 1'b1;
        drain("pp");
        check("pp_ncap", 32'(cap.size()), 32'd3);
        check("pp_e0", 32'(cap[0]), 32'h022);
        check("pp_e1", 32'(cap[1]), 32'h133);
        check("pp_e2", 32'(cap[2]), 32'h044);

        // Reset mid-transfer with COUNT 5; WR_EN during reset ignored
        auto_ack = 1'b0;
        LCD_READY = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + 8'(i)), 1'b0);
        LCD_READY = 1'b1;
        tick();
        check("r_load", 32'(LCD_LOAD), 32'd1);
        check("r_count5", 32'(COUNT), 32'd5);
        RESET = 1'b1;
        WR_EN = 1'b1;
        WR_DATA = 8'hEE;
        tick();
        check("r_load0", 32'(LCD_LOAD), 32'd0);
        check("r_count0", 32'(COUNT), 32'd0);
        check("r_empty", 32'(EMPTY), 32'd1);
        check("r_data0", 32'({LCD_IS_CMD, LCD_DATA}), 32'd0);
        RESET = 1'b0;
        WR_EN = 1'b0;
        tick();
        check("r_wr_ignored", 32'(COUNT), 32'd0);
        push(8'h77, 1'b1);
        check("r_idle_count", 32'(COUNT), 32'd1);
        tick();
        check("r_idle_load", 32'({LCD_LOAD, LCD_IS_CMD, LCD_DATA}), 32'h377);
        LCD_BUSY = 1'b1;
        tick();
        LCD_BUSY = 1'b0;
        tick();
        tick();

        // LOAD never acknowledged
        push(8'h81, 1'b1);
        push(8'h82, 1'b0);
        check("t_load", 32'({LCD_LOAD, LCD_IS_CMD, LCD_DATA}), 32'h381);
        k = 0;
        pulses = 0;
`ifdef LCD_QUEUE_ACK_TIMEOUT_EN
        while (LCD_LOAD && k < 1100) begin
            tick();
            k++;
            if (TIMEOUT) pulses++;
        end
        check("t_cycles", 32'(k), 32'd1024);
        check("t_pulse", 32'(TIMEOUT), 32'd1);
        tick();
        if (TIMEOUT) pulses++;
        check("t_pulse_end", 32'(TIMEOUT), 32'd0);
        check("t_pulses", 32'(pulses), 32'd1);
        check("t_next", 32'({LCD_LOAD, LCD_IS_CMD, LCD_DATA}), 32'h282);
        check("t_count", 32'(COUNT), 32'd1);
`else
        while (k < 1100) begin
            tick();
            k++;
            if (TIMEOUT) pulses++;
        end
        check("t_hold", 32'({LCD_LOAD, LCD_IS_CMD, LCD_DATA}), 32'h381);
        check("t_pulses", 32'(pulses), 32'd0);
        check("t_count", 32'(COUNT), 32'd2);
`endif
        RESET = 1'b1;
        tick();
        RESET = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
